// File: rtl/kpg_pkg.sv
// ---------------------------------------------------------------------------
// kpg_pkg
// Shared kill/propagate/generate definitions for the prefix-tree arithmetic
// blocks (the combinational KPG adder and sub24bit_pl).
//
// Contents:
//   kpg_t      2-bit KPG code {any, all}
//   KPG_KILL   2'b00 : carry out is 0 regardless of carry in
//   KPG_PROP   2'b10 : carry out equals carry in
//   KPG_GEN    2'b11 : carry out is 1 regardless of carry in
//   kpg_merge  combine a higher-order group (hi) with the group below it (lo)
// ---------------------------------------------------------------------------
package kpg_pkg;

    typedef logic [1:0] kpg_t;

    localparam kpg_t KPG_KILL = 2'b00;
    localparam kpg_t KPG_PROP = 2'b10;
    localparam kpg_t KPG_GEN  = 2'b11;

    // A propagating upper group defers to whatever the lower group resolves to.
    function automatic kpg_t kpg_merge(input kpg_t hi, input kpg_t lo);
        return (hi == KPG_PROP) ? lo : hi;
    endfunction

endpackage

// File: rtl/kpg_merge_cell.sv
// ---------------------------------------------------------------------------
// kpg_merge_cell
// One node of the KPG prefix tree: purely combinational merge of two codes.
//
// Ports:
//   i_hi   input  kpg_t  code of the more significant group
//   i_lo   input  kpg_t  code of the adjacent less significant group
//   o_out  output kpg_t  merged code covering both groups
// ---------------------------------------------------------------------------
module kpg_merge_cell
    import kpg_pkg::*;
(
    input  kpg_t i_hi,
    input  kpg_t i_lo,
    output kpg_t o_out
);

    assign o_out = kpg_merge(i_hi, i_lo);

endmodule

// File: rtl/sub24bit_pl.sv
// ---------------------------------------------------------------------------
// sub24bit_pl
// Two-stage pipelined subtractor, diff = a - b, built as a + ~b + 1 on a
// Kogge-Stone style KPG prefix tree. Spans 1, 2, 4 are resolved before the
// first register, spans 8 and 16 after it. Valid/ready handshake on both
// sides, full occupancy without bubbles.
//
// Build option:
//   SUB24_SATURATE_EN  when defined, a borrowing result is clamped to 0
//                      (borrow still reports 1). Port list is unchanged.
//
// Ports:
//   clk       input   rising-edge clock
//   rst_n     input   synchronous active-low reset
//   a         input   [WIDTH-1:0] minuend
//   b         input   [WIDTH-1:0] subtrahend
//   validIn   input   operands present
//   readyIn   output  block can accept operands this cycle
//   diff      output  [WIDTH-1:0] a - b modulo 2^WIDTH
//   borrow    output  1 when a < b (unsigned)
//   validOut  output  diff/borrow valid
//   readyOut  input   downstream accepts result
// ---------------------------------------------------------------------------
module sub24bit_pl
    import kpg_pkg::*;
#(
    parameter int WIDTH = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             validIn,
    output logic             readyIn,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             validOut,
    input  logic             readyOut
);

    // Slot 0 carries the +1 carry-in; slot i+1 describes operand bit i.
    localparam int SLOTS  = WIDTH + 1;
    localparam int LEVELS = $clog2(SLOTS);
    localparam int SPLIT  = (LEVELS < 3) ? LEVELS : 3;

    // ---------------- stage 0: per-bit KPG and low prefix levels ----------
    kpg_t             w_init [0:SLOTS-1];
    kpg_t             w_s1_next [0:SLOTS-1];
    logic [WIDTH-1:0] w_nb;
    logic [WIDTH-1:0] w_p;

    assign w_nb      = ~b;
    assign w_p       = a ^ w_nb;
    assign w_init[0] = KPG_GEN;

    genvar gi, gl;
    generate
        // {x|y, x&y} maps 00->KILL, one-hot->PROP, 11->GEN.
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign w_init[gi+1] = {a[gi] | w_nb[gi], a[gi] & w_nb[gi]};
        end

        for (gl = 0; gl < SPLIT; gl++) begin : g_lo
            localparam int SPAN = 1 << gl;
            kpg_t w_in  [0:SLOTS-1];
            kpg_t w_out [0:SLOTS-1];
            if (gl == 0) begin : g_src
                assign w_in = w_init;
            end else begin : g_src
                assign w_in = g_lo[gl-1].w_out;
            end
            for (gi = 0; gi < SLOTS; gi++) begin : g_slot
                if (gi >= SPAN) begin : g_merge
                    kpg_merge_cell u_cell (
                        .i_hi  (w_in[gi]),
                        .i_lo  (w_in[gi-SPAN]),
                        .o_out (w_out[gi])
                    );
                end else begin : g_pass
                    assign w_out[gi] = w_in[gi];
                end
            end
        end
    endgenerate

    assign w_s1_next = g_lo[SPLIT-1].w_out;

    // ---------------- handshake -------------------------------------------
    logic r_s1_valid;
    logic r_s2_valid;
    logic w_adv;
    logic w_accept;

    assign w_adv    = !r_s2_valid || readyOut;
    assign readyIn  = !r_s1_valid || !r_s2_valid || readyOut;
    assign w_accept = validIn && readyIn;

    // ---------------- stage 1 register ------------------------------------
    kpg_t             r_s1_kpg [0:SLOTS-1];
    logic [WIDTH-1:0] r_s1_p;

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_s1_kpg <= w_s1_next;
            r_s1_p   <= w_p;
        end
    end

    // ---------------- stage 2: remaining prefix levels --------------------
    kpg_t             w_res [0:SLOTS-1];
    logic [WIDTH:0]   w_carry;
    logic [WIDTH-1:0] w_diff_mod;
    logic [WIDTH-1:0] w_diff_next;
    logic             w_borrow_next;

    generate
        for (gl = SPLIT; gl < LEVELS; gl++) begin : g_hi
            localparam int SPAN = 1 << gl;
            kpg_t w_in  [0:SLOTS-1];
            kpg_t w_out [0:SLOTS-1];
            if (gl == SPLIT) begin : g_src
                assign w_in = r_s1_kpg;
            end else begin : g_src
                assign w_in = g_hi[gl-1].w_out;
            end
            for (gi = 0; gi < SLOTS; gi++) begin : g_slot
                if (gi >= SPAN) begin : g_merge
                    kpg_merge_cell u_cell (
                        .i_hi  (w_in[gi]),
                        .i_lo  (w_in[gi-SPAN]),
                        .o_out (w_out[gi])
                    );
                end else begin : g_pass
                    assign w_out[gi] = w_in[gi];
                end
            end
        end

        if (LEVELS > SPLIT) begin : g_res
            assign w_res = g_hi[LEVELS-1].w_out;
        end else begin : g_res
            assign w_res = r_s1_kpg;
        end

        // Every slot is now KILL or GEN, so either code bit gives the carry.
        for (gi = 0; gi < SLOTS; gi++) begin : g_carry
            assign w_carry[gi] = w_res[gi][1] | w_res[gi][0];
        end
    endgenerate

    assign w_diff_mod    = r_s1_p ^ w_carry[WIDTH-1:0];
    assign w_borrow_next = ~w_carry[WIDTH];

`ifdef SUB24_SATURATE_EN
    assign w_diff_next = w_borrow_next ? '0 : w_diff_mod;
`else
    assign w_diff_next = w_diff_mod;
`endif

    // ---------------- stage 2 register and valid tracking -----------------
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
            r_diff     <= '0;
            r_borrow   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_s1_valid <= 1'b1;
            end else if (w_adv) begin
                r_s1_valid <= 1'b0;
            end
            if (w_adv) begin
                r_s2_valid <= r_s1_valid;
                // Only a real item overwrites the outputs, so idle cycles
                // leave the last result untouched.
                if (r_s1_valid) begin
                    r_diff   <= w_diff_next;
                    r_borrow <= w_borrow_next;
                end
            end
        end
    end

    assign diff     = r_diff;
    assign borrow   = r_borrow;
    assign validOut = r_s2_valid;

endmodule

// File: tb/tb_sub24bit_pl.sv
module tb_sub24bit_pl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [23:0] a;
    logic [23:0] b;
    logic        validIn;
    logic        readyIn;
    logic [23:0] diff;
    logic        borrow;
    logic        validOut;
    logic        readyOut;

    int checks = 0;
    int errors = 0;

    logic [23:0] va [0:99];
    logic [23:0] vb [0:99];

    sub24bit_pl #(.WIDTH(24)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .a        (a),
        .b        (b),
        .validIn  (validIn),
        .readyIn  (readyIn),
        .diff     (diff),
        .borrow   (borrow),
        .validOut (validOut),
        .readyOut (readyOut)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] exp_diff(input logic [23:0] x, input logic [23:0] y);
        logic [24:0] t;
        t = {1'b0, x} - {1'b0, y};
`ifdef SUB24_SATURATE_EN
        if (t[24]) return 24'h0;
`endif
        return t[23:0];
    endfunction

    function automatic logic exp_borrow(input logic [23:0] x, input logic [23:0] y);
        logic [24:0] t;
        t = {1'b0, x} - {1'b0, y};
        return t[24];
    endfunction

    // Single transaction into an empty pipeline with readyOut=1.
    task automatic send_one(input string tag, input logic [23:0] x, input logic [23:0] y,
                            input logic [23:0] ed, input logic eb);
        @(negedge clk);
        a = x; b = y; validIn = 1'b1; readyOut = 1'b1;
        #1;
        check({tag, "_readyIn"}, {31'd0, readyIn}, 32'd1);
        @(negedge clk);
        validIn = 1'b0;
        check({tag, "_vo_lat1"}, {31'd0, validOut}, 32'd0);
        @(negedge clk);
        check({tag, "_vo_lat2"}, {31'd0, validOut}, 32'd1);
        check({tag, "_diff"}, {8'd0, diff}, {8'd0, ed});
        check({tag, "_borrow"}, {31'd0, borrow}, {31'd0, eb});
        $display("txn %s: a=%h b=%h diff=%h borrow=%0d", tag, x, y, diff, borrow);
        @(negedge clk);
        check({tag, "_vo_drain"}, {31'd0, validOut}, 32'd0);
    endtask

    initial begin
        int sent;
        int got;
        rst_n = 1'b0; a = '0; b = '0; validIn = 1'b0; readyOut = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_validOut", {31'd0, validOut}, 32'd0);
        check("rst_diff", {8'd0, diff}, 32'd0);
        check("rst_borrow", {31'd0, borrow}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_readyIn", {31'd0, readyIn}, 32'd1);

        // Directed vectors; expected values written out by hand.
        send_one("basic", 24'h000005, 24'h000003, 24'h000002, 1'b0);
`ifdef SUB24_SATURATE_EN
        send_one("underflow", 24'h000000, 24'h000001, 24'h000000, 1'b1);
        send_one("wrap_big", 24'h000010, 24'hFFFFFF, 24'h000000, 1'b1);
`else
        send_one("underflow", 24'h000000, 24'h000001, 24'hFFFFFF, 1'b1);
        send_one("wrap_big", 24'h000010, 24'hFFFFFF, 24'h000011, 1'b1);
`endif
        send_one("carry_chain", 24'h800000, 24'h7FFFFF, 24'h000001, 1'b0);
        send_one("equal", 24'hABCDEF, 24'hABCDEF, 24'h000000, 1'b0);
        send_one("max_minus0", 24'hFFFFFF, 24'h000000, 24'hFFFFFF, 1'b0);

        // Backpressure: 10-1, 20-2, 30-3, 40-4 with readyOut low 3 cycles.
        for (int i = 0; i < 4; i++) begin
            va[i] = 24'(10 * (i + 1));
            vb[i] = 24'(i + 1);
        end
        sent = 0; got = 0;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            readyOut = (c >= 3);
            validIn  = (sent < 4);
            a = (sent < 4) ? va[sent] : 24'h0;
            b = (sent < 4) ? vb[sent] : 24'h0;
            #1;
            if (c == 2) begin
                check("bp_readyIn_low", {31'd0, readyIn}, 32'd0);
                check("bp_vo_held", {31'd0, validOut}, 32'd1);
                check("bp_sent_before_stall", sent, 2);
            end
            if (c == 2 || c == 3) check("bp_diff_held", {8'd0, diff}, 32'd9);
            if (validOut && readyOut) begin
                check("bp_result", {8'd0, diff}, 32'(9 * (got + 1)));
                check("bp_borrow", {31'd0, borrow}, 32'd0);
                $display("txn bp[%0d]: diff=%0d", got, diff);
                got++;
            end
            if (validIn && readyIn) sent++;
        end
        validIn = 1'b0;
        check("bp_all_sent", sent, 4);
        check("bp_all_got", got, 4);

        // Streaming: 100 random pairs, one result per cycle after fill.
        for (int i = 0; i < 100; i++) begin
            va[i] = 24'($urandom);
            vb[i] = 24'($urandom);
        end
        va[7] = 24'h123456; vb[7] = 24'h123456;
        sent = 0; got = 0;
        for (int c = 0; c < 102; c++) begin
            @(negedge clk);
            readyOut = 1'b1;
            validIn  = (sent < 100);
            a = (sent < 100) ? va[sent] : 24'h0;
            b = (sent < 100) ? vb[sent] : 24'h0;
            #1;
            if (c == 1) check("st_fill_vo", {31'd0, validOut}, 32'd0);
            if (c >= 2) check("st_vo_every_cycle", {31'd0, validOut}, 32'd1);
            if (validOut && readyOut && got < 100) begin
                check("st_diff", {8'd0, diff}, {8'd0, exp_diff(va[got], vb[got])});
                check("st_borrow", {31'd0, borrow}, {31'd0, exp_borrow(va[got], vb[got])});
                $display("txn st[%0d]: a=%h b=%h diff=%h borrow=%0d", got, va[got], vb[got], diff, borrow);
                got++;
            end
            if (validIn && readyIn) sent++;
        end
        validIn = 1'b0;
        check("st_got", got, 100);

        // Reset mid-flight: fill the pipe with readyOut low, then reset.
        @(negedge clk);
        readyOut = 1'b0;
        a = 24'h000100; b = 24'h000001; validIn = 1'b1;
        @(negedge clk);
        a = 24'h000200; b = 24'h000002;
        @(negedge clk);
        check("mid_full_vo", {31'd0, validOut}, 32'd1);
        check("mid_full_readyIn", {31'd0, readyIn}, 32'd0);
        validIn = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("mid_rst_vo", {31'd0, validOut}, 32'd0);
        check("mid_rst_diff", {8'd0, diff}, 32'd0);
        check("mid_rst_borrow", {31'd0, borrow}, 32'd0);
        check("mid_rst_readyIn", {31'd0, readyIn}, 32'd1);
        send_one("after_rst", 24'h123456, 24'h000456, 24'h123000, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sub24bit_pl.md
Name: sub24bit_pl

Overview:
- Two-stage pipelined 24-bit subtractor, diff = a - b. It is the inverse operation of the team's combinational KPG prefix adder.
- Uses the same kill/propagate/generate prefix scheme on a + ~b + 1. The prefix tree is split across a register boundary.
- Carries a valid/ready handshake on both sides, so it drops into the datapath between the operand-select logic and the normalise stage.

Parameters:
- WIDTH, 24, operand width. Only 24 is verified; the prefix tree is sized to ceil(log2(WIDTH+1)) levels.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- a  input  WIDTH  minuend
- b  input  WIDTH  subtrahend
- validIn  input  1  operands present
- readyIn  output  1  block can accept operands this cycle
- diff  output  WIDTH  a - b modulo 2^WIDTH
- borrow  output  1  1 when a < b (unsigned)
- validOut  output  1  diff/borrow valid
- readyOut  input  1  downstream accepts result

Behaviour:
- Reset: sampled on clk when rst_n=0. Clears s1Valid, s2Valid, validOut=0, diff=0, borrow=0. readyIn=1 from the first cycle after reset release.
- Reset mid-operation: all in-flight data is discarded, with no partial outputs. validOut=0 on the cycle following the reset edge.
- Stage 0 (combinational, input side):
  - Per-bit KPG of a[i] and ~b[i].
  - Slot 0 is forced to GENERATE (carry-in 1).
  - Prefix levels of span 1, 2 and 4 are computed.
- Stage 1 register: holds the level-3 KPG vector and a^~b. Loads when validIn && readyIn.
- Stage 2 (combinational from the s1 register): prefix levels of span 8 and 16 resolve every slot to KILL or GENERATE.
  - carry[i] = OR of the two code bits of resolved slot i.
  - diff[i] = (a[i]^~b[i]) ^ carry[i].
  - borrow = ~carry[WIDTH].
- Stage 2 register: drives diff, borrow, validOut.
- Latency: result is on the outputs 2 cycles after input acceptance. Throughput is 1 per cycle when readyOut=1.
- Handshake:
  - Transfer occurs on clk where valid && ready.
  - s2 advances when !s2Valid || readyOut.
  - s1 advances into s2 under the same condition.
  - readyIn = !s1Valid || !s2Valid || readyOut, which gives full occupancy with no bubble.
  - Outputs are held stable while validOut && !readyOut.
- Simultaneous accept and drain in one cycle is legal. Occupancy is unchanged.
- No combinational path from validIn to validOut. The only combinational path from readyOut to readyIn is through the expression above.
- Wrap-around: a < b yields the 2^WIDTH modular result with borrow=1. a = b yields diff=0, borrow=0.

Optional Feature:
- Macro SUB24_SATURATE_EN.
- Defined: when borrow=1, diff is forced to 0 at the stage-2 register input; borrow still reports 1.
- Undefined: modular result as above. Port list is identical in both builds.

Decomposition:
- Shared package kpg_pkg holds:
  - typedef kpg_t (logic [1:0])
  - constants KPG_KILL=2'b00, KPG_PROP=2'b10, KPG_GEN=2'b11
  - function kpg_merge(hi, lo): returns hi unless hi==KPG_PROP, in which case it returns lo
- One sub-module, kpg_merge_cell: combinational merge of two kpg_t. It is instantiated across the prefix levels by generate loops.
- Pipeline registers and handshake stay in sub24bit_pl.

Test Plan:
- Basic subtract: a=0x000005, b=0x000003, validIn for 1 cycle, readyOut=1 -> validOut high exactly 2 cycles later, diff=0x000002, borrow=0.
- Underflow: a=0x000000, b=0x000001 -> diff=0xFFFFFF, borrow=1. With SUB24_SATURATE_EN: diff=0x000000, borrow=1.
- Full carry chain: a=0x800000, b=0x7FFFFF -> diff=0x000001, borrow=0. Also a=b=0xABCDEF -> diff=0, borrow=0.
- Backpressure: 4 back-to-back inputs (10-1, 20-2, 30-3, 40-4) with readyOut held low for 3 cycles -> readyIn drops after 2 accepted; outputs held stable; results 9, 18, 27, 36 delivered in order with no loss or duplication.
- Streaming: 100 random pairs with readyOut=1 and validIn=1 -> one result per cycle after 2-cycle fill; each result matches the reference model (a-b) mod 2^24 with borrow=(a<b).
- Reset mid-flight: pipeline full and readyOut=0, rst_n=0 for 1 cycle -> validOut=0, diff=0, borrow=0 next cycle, readyIn=1. The first new input afterwards produces the correct result 2 cycles later.
